// File: rtl/dl_pkg.sv
// Shared types for the DL IQ block ping-pong buffer.
package dl_pkg;

  localparam int BLK_LEN_DEF = 819;  // beats per IQ block (SCS_NUM/4)

  typedef struct packed {
    logic [15:0] frame;
    logic [7:0]  slot;
    logic [7:0]  symbol;
    logic [7:0]  ante;
  } iq_tag_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_SKIP
  } w_state_t;

endpackage

// File: rtl/dl_bank_ram.sv
// Two-bank simple dual-port RAM. Bank 1 occupies the upper BLK_LEN words.
// Synchronous read with one cycle of latency.
module dl_bank_ram #(
  parameter int DATA_W  = 64,
  parameter int BLK_LEN = 819,
  parameter int IW      = 10
) (
  input  logic              clk_in,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [IW-1:0]     widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rbank_i,
  input  logic [IW-1:0]     ridx_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 2 * BLK_LEN;
  localparam int AW    = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  function automatic logic [AW-1:0] addr(input logic bank, input logic [IW-1:0] idx);
    return bank ? (AW'(BLK_LEN) + AW'(idx)) : AW'(idx);
  endfunction

  // write port
  always_ff @(posedge clk_in) begin
    if (we_i) mem_q[addr(wbank_i, widx_i)] <= wdata_i;
  end

  // registered read port
  always_ff @(posedge clk_in) begin
    if (re_i) rdata_o <= mem_q[addr(rbank_i, ridx_i)];
  end

endmodule

// File: rtl/dl_blk_pingpong.sv
// DL IQ block ping-pong buffer: length-checks incoming blocks, stores them in
// two banks, and replays committed blocks in commit order over valid/ready.
module dl_blk_pingpong
  import dl_pkg::*;
#(
  parameter int BLK_LEN = BLK_LEN_DEF,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic [DATA_W-1:0] din_data,
  input  logic [15:0]       din_frame,
  input  logic [7:0]        din_slot,
  input  logic [7:0]        din_symbol,
  input  logic [7:0]        din_ante,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [DATA_W-1:0] dout_data,
  output logic [15:0]       dout_frame,
  output logic [7:0]        dout_slot,
  output logic [7:0]        dout_symbol,
  output logic [7:0]        dout_ante,
  output logic [1:0]        bank_full,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  len_err_cnt
);
  localparam int IW = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam int CW = $clog2(BLK_LEN + 2);  // holds BLK_LEN+1 without overflow
  localparam logic [CW-1:0] LEN_C  = CW'(BLK_LEN);
  localparam logic [IW-1:0] LAST_I = IW'(BLK_LEN - 1);

  // ---------------- write side ----------------
  w_state_t          st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_sel_q, wr_sel_d;
  iq_tag_t           tag_q [2];
  logic [1:0]        full_q, fetched_q;
  logic [CNT_W-1:0]  drop_q, lerr_q;
  logic              we, commit, drop_inc, lerr_inc, tag_ld;
  logic [IW-1:0]     widx;
  iq_tag_t           din_tag;

  assign din_tag = '{frame: din_frame, slot: din_slot, symbol: din_symbol, ante: din_ante};

  // write FSM: block framing, length check and bank admission
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    wr_sel_d = wr_sel_q;
    we       = 1'b0;
    widx     = '0;
    commit   = 1'b0;
    drop_inc = 1'b0;
    lerr_inc = 1'b0;
    tag_ld   = 1'b0;
    if (din_valid) begin
      if (din_sop) begin
        // a sop inside a block aborts it; the restart reuses the same (empty) bank
        if (st_q == W_FILL) lerr_inc = 1'b1;
        if (st_q != W_FILL && full_q[wr_sel_q]) begin
          drop_inc = 1'b1;
          st_d     = din_eop ? W_IDLE : W_SKIP;
        end else begin
          we     = 1'b1;
          tag_ld = 1'b1;
          cnt_d  = CW'(1);
          if (din_eop) begin
            st_d = W_IDLE;
            if (BLK_LEN == 1) commit = 1'b1;
            else              lerr_inc = 1'b1;
          end else begin
            st_d = W_FILL;
          end
        end
      end else if (st_q == W_FILL) begin
        if (din_eop) begin
          st_d = W_IDLE;
          if (cnt_q + CW'(1) == LEN_C) begin
            we     = 1'b1;
            widx   = IW'(cnt_q);
            commit = 1'b1;
          end else begin
            lerr_inc = 1'b1;
          end
        end else if (cnt_q == LEN_C) begin
          lerr_inc = 1'b1;
          st_d     = W_SKIP;
        end else begin
          we    = 1'b1;
          widx  = IW'(cnt_q);
          cnt_d = cnt_q + CW'(1);
        end
      end else if (st_q == W_SKIP && din_eop) begin
        st_d = W_IDLE;
      end
    end
    if (commit) wr_sel_d = ~wr_sel_q;
  end

  // write-side state, tags and saturating counters
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= W_IDLE;
      cnt_q    <= '0;
      wr_sel_q <= 1'b0;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
      drop_q   <= '0;
      lerr_q   <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      wr_sel_q <= wr_sel_d;
      if (tag_ld) tag_q[wr_sel_q] <= din_tag;
      if (drop_inc && drop_q != '1) drop_q <= drop_q + CNT_W'(1);
      if (lerr_inc && lerr_q != '1) lerr_q <= lerr_q + CNT_W'(1);
    end
  end

  // ---------------- read side ----------------
  logic              rd_sel_q, fe_sel_q;
  logic [IW-1:0]     fe_idx_q;
  logic              fe_go, pop, rel;
  logic              rd_vld_q, rd_sop_q, rd_eop_q, rd_bank_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] sk_data_q [2];
  logic [1:0]        sk_sop_q, sk_eop_q, sk_bank_q;
  logic              sk_wp_q, sk_rp_q;
  logic [1:0]        sk_cnt_q;
  iq_tag_t           out_tag;

  assign pop = dout_valid & dout_ready;
  assign rel = pop & dout_eop;
  // fetch only while the skid plus the in-flight read leaves a free slot
  assign fe_go = full_q[fe_sel_q] & ~fetched_q[fe_sel_q] &
                 (({1'b0, sk_cnt_q} + {2'b00, rd_vld_q}) < (3'd2 + {2'b00, pop}));

  dl_bank_ram #(.DATA_W(DATA_W), .BLK_LEN(BLK_LEN), .IW(IW)) u_ram (
    .clk_in  (clk_in),
    .we_i    (we),
    .wbank_i (wr_sel_q),
    .widx_i  (widx),
    .wdata_i (din_data),
    .re_i    (fe_go),
    .rbank_i (fe_sel_q),
    .ridx_i  (fe_idx_q),
    .rdata_o (ram_rdata)
  );

  // bank ownership: set on commit, cleared on the eop handshake
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      fetched_q <= '0;
    end else begin
      if (commit) full_q[wr_sel_q] <= 1'b1;
      if (fe_go && fe_idx_q == LAST_I) fetched_q[fe_sel_q] <= 1'b1;
      if (rel) begin
        full_q[rd_sel_q]    <= 1'b0;
        fetched_q[rd_sel_q] <= 1'b0;
      end
    end
  end

  // fetch pointer, read pipeline and 2-entry output skid
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel_q     <= 1'b0;
      fe_sel_q     <= 1'b0;
      fe_idx_q     <= '0;
      rd_vld_q     <= 1'b0;
      rd_sop_q     <= 1'b0;
      rd_eop_q     <= 1'b0;
      rd_bank_q    <= 1'b0;
      sk_data_q[0] <= '0;
      sk_data_q[1] <= '0;
      sk_sop_q     <= '0;
      sk_eop_q     <= '0;
      sk_bank_q    <= '0;
      sk_wp_q      <= 1'b0;
      sk_rp_q      <= 1'b0;
      sk_cnt_q     <= '0;
    end else begin
      rd_vld_q <= fe_go;
      if (fe_go) begin
        rd_sop_q  <= (fe_idx_q == '0);
        rd_eop_q  <= (fe_idx_q == LAST_I);
        rd_bank_q <= fe_sel_q;
        if (fe_idx_q == LAST_I) begin
          fe_idx_q <= '0;
          fe_sel_q <= ~fe_sel_q;
        end else begin
          fe_idx_q <= fe_idx_q + IW'(1);
        end
      end
      if (rd_vld_q) begin
        sk_data_q[sk_wp_q] <= ram_rdata;
        sk_sop_q[sk_wp_q]  <= rd_sop_q;
        sk_eop_q[sk_wp_q]  <= rd_eop_q;
        sk_bank_q[sk_wp_q] <= rd_bank_q;
        sk_wp_q            <= ~sk_wp_q;
      end
      if (pop) sk_rp_q <= ~sk_rp_q;
      sk_cnt_q <= sk_cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
      if (rel) rd_sel_q <= ~rd_sel_q;
    end
  end

  assign out_tag     = tag_q[sk_bank_q[sk_rp_q]];
  assign dout_valid  = (sk_cnt_q != 2'd0);
  assign dout_data   = sk_data_q[sk_rp_q];
  assign dout_sop    = sk_sop_q[sk_rp_q];
  assign dout_eop    = sk_eop_q[sk_rp_q];
  assign dout_frame  = out_tag.frame;
  assign dout_slot   = out_tag.slot;
  assign dout_symbol = out_tag.symbol;
  assign dout_ante   = out_tag.ante;
  assign bank_full   = full_q;
  assign drop_cnt    = drop_q;
  assign len_err_cnt = lerr_q;

endmodule

// File: tb/tb_dl_blk_pingpong.sv
// Scoreboard bench for dl_blk_pingpong with BLK_LEN=8.
module tb_dl_blk_pingpong;
  localparam int BL = 8;
  localparam int DW = 64;
  localparam int CW = 16;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b1;
  logic          din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic [DW-1:0] din_data = '0;
  logic [15:0]   din_frame = '0;
  logic [7:0]    din_slot = '0, din_symbol = '0, din_ante = '0;
  logic          dout_valid, dout_ready = 1'b1, dout_sop, dout_eop;
  logic [DW-1:0] dout_data;
  logic [15:0]   dout_frame;
  logic [7:0]    dout_slot, dout_symbol, dout_ante;
  logic [1:0]    bank_full;
  logic [CW-1:0] drop_cnt, len_err_cnt;

  always #5 clk_in = ~clk_in;

  dl_blk_pingpong #(.BLK_LEN(BL), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop), .din_data(din_data),
    .din_frame(din_frame), .din_slot(din_slot), .din_symbol(din_symbol), .din_ante(din_ante),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_data(dout_data), .dout_frame(dout_frame), .dout_slot(dout_slot),
    .dout_symbol(dout_symbol), .dout_ante(dout_ante),
    .bank_full(bank_full), .drop_cnt(drop_cnt), .len_err_cnt(len_err_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic        sop, eop;
    logic [39:0] tag;
  } beat_t;

  beat_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int committed = 0, released = 0;   // blocks stored = committed - released
  int drop_exp = 0, lerr_exp = 0;
  int ready_mode = 0;                // 0 always, 1 toggle, 2 hold low, 3 random

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic idle_beat();
    din_valid = 1'b0;
    din_sop   = 1'($urandom);
    din_eop   = 1'($urandom);
    din_data  = {$urandom, $urandom};
    tick();
  endtask

  // Drive one block. Model: the block is admitted if fewer than two blocks
  // are stored at its sop; it is output only if it has exactly BL beats,
  // framed by sop..eop. A cut block (no eop) is aborted by the next sop.
  task automatic send_block(input int len, input bit cut, input bit gaps,
                            input logic [63:0] base, input logic [39:0] tag);
    bit acc, good;
    beat_t e;
    acc = 1'b0;
    good = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) idle_beat();
      if (i == 0) begin
        acc  = (committed - released) < 2;
        good = acc && !cut && (len == BL);
        if (!acc) drop_exp++;
        else if (!good) lerr_exp++;
      end
      din_valid = 1'b1;
      din_sop   = (i == 0);
      din_eop   = !cut && (i == len - 1);
      din_data  = base + 64'(i);
      // tags only matter on the sop beat; scramble them elsewhere
      {din_frame, din_slot, din_symbol, din_ante} = (i == 0) ? tag : {8'($urandom), $urandom};
      if (good) begin
        e.data = base + 64'(i);
        e.sop  = (i == 0);
        e.eop  = (i == len - 1);
        e.tag  = tag;
        exp_q.push_back(e);
        if (i == len - 1) committed++;
      end
      tick();
    end
    din_valid = 1'b0;
    din_sop   = 1'b0;
    din_eop   = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      tick();
      t++;
    end
    repeat (6) tick();
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("bank_full_idle", 64'(bank_full), 64'd0);
    chk("drop_cnt", 64'(drop_cnt), 64'(drop_exp));
    chk("len_err_cnt", 64'(len_err_cnt), 64'(lerr_exp));
  endtask

  // ready generator
  initial forever begin
    @(posedge clk_in); #1;
    case (ready_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ~dout_ready;
      2:       dout_ready = 1'b0;
      default: dout_ready = 1'($urandom);
    endcase
  end

  // monitor: pops the scoreboard on each handshake; checks hold during stalls
  initial begin
    beat_t e;
    bit stall;
    logic [63:0] h_data;
    logic h_sop, h_eop;
    stall = 1'b0;
    h_data = '0;
    h_sop = 1'b0;
    h_eop = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_ctl", 64'({dout_valid, dout_sop, dout_eop}), 64'({1'b1, h_sop, h_eop}));
          chk("stall_data", dout_data, h_data);
        end
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h, expected no beat", dout_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", dout_data, e.data);
            chk("out_sop_eop", 64'({dout_sop, dout_eop}), 64'({e.sop, e.eop}));
            chk("out_tag", 64'({dout_frame, dout_slot, dout_symbol, dout_ante}), 64'(e.tag));
            if (e.eop) released++;
          end
        end
        stall  = dout_valid && !dout_ready;
        h_data = dout_data;
        h_sop  = dout_sop;
        h_eop  = dout_eop;
      end
    end
  end

  initial begin
    int k, len;
    bit cut, prev_cut;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ctl", 64'({dout_valid, dout_sop, dout_eop, bank_full}), 64'd0);
    chk("rst_data", dout_data, 64'd0);
    chk("rst_tags", 64'({dout_frame, dout_slot, dout_symbol, dout_ante}), 64'd0);
    chk("rst_cnt", 64'({drop_cnt, len_err_cnt}), 64'd0);
    #19 rst_n = 1'b1;
    tick();

    // single good block, latency from the commit edge
    ready_mode = 0;
    send_block(BL, 1'b0, 1'b0, 64'd0, {16'h0123, 8'd3, 8'd5, 8'd2});
    chk("lat_e0", 64'(dout_valid), 64'd0);
    tick();
    chk("lat_e1", 64'(dout_valid), 64'd0);
    tick();
    chk("lat_e2", 64'(dout_valid), 64'd1);
    drain();

    // same block with toggling ready
    ready_mode = 1;
    send_block(BL, 1'b0, 1'b0, 64'd0, {16'h0123, 8'd3, 8'd5, 8'd2});
    drain();

    // three back-to-back blocks while the consumer is stalled
    ready_mode = 2;
    dout_ready = 1'b0;
    for (int b = 0; b < 3; b++)
      send_block(BL, 1'b0, 1'b0, {32'(b + 16), 32'd0}, {16'(b), 8'h10, 8'h20, 8'(b)});
    repeat (3) tick();
    chk("bank_full_both", 64'(bank_full), 64'd3);
    chk("drop_when_full", 64'(drop_cnt), 64'(drop_exp));
    ready_mode = 0;
    drain();

    // short block then good block
    send_block(5, 1'b0, 1'b0, 64'h500, 40'h11);
    send_block(BL, 1'b0, 1'b0, 64'h600, 40'h22);
    drain();

    // 9-beat block, a block cut by the next sop at beat 4, then a good block
    send_block(BL + 1, 1'b0, 1'b0, 64'h700, 40'h33);
    send_block(4, 1'b1, 1'b0, 64'h800, 40'h44);
    send_block(BL, 1'b0, 1'b0, 64'h900, 40'h55);
    drain();

    // randomized traffic with random ready, gaps and stray beats
    ready_mode = 3;
    prev_cut = 1'b0;
    for (int b = 0; b < 40; b++) begin
      k = (b == 39) ? 0 : int'($urandom_range(0, 9));
      cut = 1'b0;
      len = BL;
      if (k == 6) len = int'($urandom_range(1, BL - 1));
      if (k == 7) len = int'($urandom_range(BL + 1, BL + 3));
      if (k == 8) begin
        cut = 1'b1;
        len = int'($urandom_range(1, BL));
      end
      if (k == 9 && !prev_cut) begin
        din_valid = 1'b1;
        din_sop   = 1'b0;
        din_eop   = 1'($urandom);
        din_data  = {$urandom, $urandom};
        tick();
        din_valid = 1'b0;
      end
      send_block(len, cut, 1'b1, {32'(b + 256), 32'd0}, {8'($urandom), $urandom});
      prev_cut = cut;
    end
    ready_mode = 0;
    drain();

    // reset while a block is mid-stream
    send_block(BL, 1'b0, 1'b0, 64'hA00, 40'h66);
    for (int t = 0; t < 50 && exp_q.size() > 4; t++) tick();
    chk("mid_block_reached", 64'(exp_q.size() <= 4 && exp_q.size() > 0), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_ctl", 64'({dout_valid, dout_sop, dout_eop, bank_full}), 64'd0);
    chk("mrst_data", dout_data, 64'd0);
    chk("mrst_cnt", 64'({drop_cnt, len_err_cnt}), 64'd0);
    exp_q.delete();
    committed = 0;
    released  = 0;
    drop_exp  = 0;
    lerr_exp  = 0;
    tick();
    rst_n = 1'b1;
    tick();
    send_block(BL, 1'b0, 1'b0, 64'hB00, 40'h77);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dl_blk_pingpong.md
Name: dl_blk_pingpong

Overview:
- Downstream neighbour of the DL IQ distributor. Consumes its per-antenna IQ block stream (valid/sop/eop, 64-bit data, frame/slot/symbol/antenna tags), which has no backpressure.
- Checks each block's length and stores it in one of two ping-pong banks.
- Replays committed blocks to the harden_tx/subcarrier-map side over a valid/ready interface, with tags held constant for the whole block.

Parameters:
- BLK_LEN, 819, beats per IQ block (SCS_NUM/4); benches use 8.
- DATA_W, 64, data width.
- CNT_W, 16, width of the error/drop counters.

Ports:
- clk_in  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- din_valid  in  1  input beat valid; no backpressure upstream
- din_sop  in  1  first beat of block
- din_eop  in  1  last beat of block
- din_data  in  DATA_W  IQ beat
- din_frame  in  16  frame index, sampled on sop beat
- din_slot  in  8  slot index, sampled on sop beat
- din_symbol  in  8  symbol index, sampled on sop beat
- din_ante  in  8  antenna index, sampled on sop beat
- dout_valid  out  1  output beat valid
- dout_ready  in  1  consumer accepts beat
- dout_sop  out  1  first output beat
- dout_eop  out  1  last output beat
- dout_data  out  DATA_W  IQ beat
- dout_frame  out  16  tag of block being output
- dout_slot  out  8  tag of block being output
- dout_symbol  out  8  tag of block being output
- dout_ante  out  8  tag of block being output
- bank_full  out  2  per-bank committed flag
- drop_cnt  out  CNT_W  blocks dropped because both banks were full; saturating
- len_err_cnt  out  CNT_W  blocks discarded for a length or framing error; saturating

Behaviour:
- Reset (async): all outputs 0; banks empty; wr_sel=0, rd_sel=0; write FSM in W_IDLE; read side idle.
- A beat is accepted only when din_valid=1.
- Write FSM states: W_IDLE, W_FILL, W_SKIP.
- W_IDLE:
  - sop beat with bank[wr_sel] empty: write word 0, latch tags, beat count=1, go to W_FILL.
  - sop beat with bank[wr_sel] full: drop_cnt++, go to W_SKIP.
  - Beats without sop are ignored.
- W_FILL, sop beat: the current block is aborted (len_err_cnt++) and a new block restarts in the same bank at word 0.
- W_FILL, eop beat with count+1==BLK_LEN: commit. Set bank_full[wr_sel] on the next edge and toggle wr_sel; go to W_IDLE.
- W_FILL, eop beat with count+1!=BLK_LEN: len_err_cnt++, discard, go to W_IDLE.
- W_FILL, non-eop beat when count==BLK_LEN: len_err_cnt++, go to W_SKIP.
- W_SKIP: ignore beats until eop (go to W_IDLE) or sop (handled as in W_IDLE).
- sop and eop on the same beat: a valid block only if BLK_LEN==1; otherwise it is a length error.
- A drop decision is made at sop and is final. A bank freed mid-block does not rescue the dropped block.
- Read side:
  - Serves banks strictly in commit order (rd_sel).
  - Memory read is synchronous, 1 cycle.
  - Output stage is a 2-entry skid, so throughput is 1 beat/cycle while dout_ready=1.
  - dout_valid rises 2 cycles after the commit edge.
  - dout_* are stable while dout_valid=1 and dout_ready=0.
  - dout_sop is on word 0 and dout_eop on word BLK_LEN-1. dout tags equal the latched tags of the bank being read.
  - The handshake of the eop beat clears bank_full[rd_sel] and toggles rd_sel.
  - The next full bank starts with no bubble beyond the 2-cycle prefetch; back-to-back streaming is allowed.
- Simultaneous events:
  - A commit on one bank and a release on the other in the same cycle both take effect.
  - Writing a bank while it is being read is impossible by construction, because bank_full gates it.
- Counters: saturate at all-ones; never wrap.
- Reset mid-operation: the partial block and all stored blocks are lost; output restarts clean.

Decomposition:
- Shared package dl_pkg:
  - BLK_LEN default.
  - iq_tag_t struct (frame 16, slot 8, symbol 8, ante 8).
  - Write-state enum.
- One sub-module, dl_bank_ram: simple dual-port RAM with depth 2*BLK_LEN, synchronous read, bank select as the address MSB region.

Test Plan:
- Single good block (BLK_LEN=8, data=i, frame 0x0123, slot 3, symbol 5, ante 2, ready=1) -> 8 output beats with data 0..7; sop on beat 0, eop on beat 7; tags match; dout_valid 2 cycles after the commit edge.
- Same block with dout_ready toggling 1,0,1,0 -> exactly 8 beats, in order, no duplicates; data held stable during stalls.
- Three back-to-back good blocks with ready=0 -> bank_full=2'b11, drop_cnt=1; then ready=1 -> blocks 0 and 1 output in order, block 2 never appears.
- Short block (eop on beat 5), then a good block -> len_err_cnt=1; only the good block is output.
- 9-beat block, then a block whose sop arrives at beat 4 of a prior block, then a good block -> len_err_cnt=2; only the last block is output.
- rst_n asserted while dout is mid-block -> all outputs 0 immediately; bank_full=0; a new block after release streams correctly.
